// File: rtl/pwm_bank_avalon.sv
// Avalon-MM PWM bank: NUM_CH channels sharing one period counter, with shadowed
// period/duty registers that reload only at period boundaries (or every clock while disabled).

module pwm_lane #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [CNT_W-1:0] wdata,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] duty,
    output logic             pwm
);
    logic [CNT_W-1:0] duty_sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty    <= '0;
            duty_sh <= '0;
            pwm     <= 1'b0;
        end else begin
            // shadow samples the pre-write value, so a write on a wrap waits one period
            if (load) duty_sh <= duty;
            if (wr)   duty    <= wdata;
            pwm <= en && (cnt < duty_sh);
        end
    end
endmodule

module pwm_bank_avalon #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick
);
    logic                         enable, pending;
    logic [CNT_W-1:0]             period, per_sh, cnt;
    logic [NUM_CH-1:0][CNT_W-1:0] duty;
    logic [NUM_CH-1:0]            duty_wr;
    logic                         wr, ctrl_wr, per_wr, wrap, load;
    logic                         unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign ctrl_wr      = wr && (address == ADDR_W'(0));
    assign per_wr       = wr && (address == ADDR_W'(1));
    assign wrap         = (cnt == per_sh);
    assign load         = ~enable | wrap;
    assign unused_wdata = ^writedata[31:CNT_W];

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_lane
            assign duty_wr[g] = wr && (address == ADDR_W'(g + 2));
            pwm_lane #(.CNT_W(CNT_W)) u_lane (
                .clk   (clk),
                .reset (reset),
                .wr    (duty_wr[g]),
                .wdata (writedata[CNT_W-1:0]),
                .load  (load),
                .en    (enable),
                .cnt   (cnt),
                .duty  (duty[g]),
                .pwm   (pwm_out[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable      <= 1'b0;
            period      <= '0;
            per_sh      <= '0;
            cnt         <= '0;
            period_tick <= 1'b0;
            pending     <= 1'b0;
        end else begin
            period_tick <= enable & wrap;
            cnt         <= load ? '0 : cnt + 1'b1;
            if (load)    per_sh <= period;
            if (per_wr)  period <= writedata[CNT_W-1:0];
            if (ctrl_wr) enable <= writedata[0];
            // a write landing on the load cycle keeps the flag up
            if (per_wr || (|duty_wr)) pending <= 1'b1;
            else if (load)            pending <= 1'b0;
        end
    end

    always_comb begin
        readdata = '0;
        if (address == ADDR_W'(0))
            readdata = {30'b0, pending, enable};
        else if (address == ADDR_W'(1))
            readdata[CNT_W-1:0] = period;
        for (int i = 0; i < NUM_CH; i++)
            if (address == ADDR_W'(i + 2))
                readdata[CNT_W-1:0] = duty[i];
    end
endmodule

// File: tb/tb_pwm_bank_avalon.sv
// Randomized and directed bench for pwm_bank_avalon against a behavioural model.

module tb_pwm_bank_avalon;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] address;
    logic              chipselect, write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_tick;

    int checks = 0;
    int failures = 0;

    pwm_bank_avalon #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .pwm_out(pwm_out), .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    // behavioural model: position within the period and the values latched for it
    bit              m_en = 0, m_pend = 0, m_tick = 0;
    int              m_per = 0, m_psh = 0, m_pos = 0;
    int              m_duty[NUM_CH], m_dsh[NUM_CH];
    bit [NUM_CH-1:0] m_pwm = '0;

    initial for (int i = 0; i < NUM_CH; i++) begin m_duty[i] = 0; m_dsh[i] = 0; end

    always @(posedge clk or posedge reset) begin
        bit wr, at_end, fresh;
        int a, d;
        if (reset) begin
            m_en = 0; m_pend = 0; m_tick = 0; m_per = 0; m_psh = 0; m_pos = 0; m_pwm = '0;
            for (int i = 0; i < NUM_CH; i++) begin m_duty[i] = 0; m_dsh[i] = 0; end
        end else begin
            wr = chipselect && !write_n;
            a = int'(address);
            d = int'(writedata) & ((1 << CNT_W) - 1);
            at_end = (m_pos == m_psh);
            fresh = !m_en || at_end;
            for (int i = 0; i < NUM_CH; i++) m_pwm[i] = m_en && (m_pos < m_dsh[i]);
            m_tick = m_en && at_end;
            m_pos = fresh ? 0 : m_pos + 1;
            if (fresh) begin
                m_psh = m_per;
                for (int i = 0; i < NUM_CH; i++) m_dsh[i] = m_duty[i];
            end
            if (wr && a >= 1 && a < NUM_CH + 2) m_pend = 1;
            else if (fresh) m_pend = 0;
            if (wr) begin
                if (a == 0) m_en = writedata[0];
                else if (a == 1) m_per = d;
                else if (a < NUM_CH + 2) m_duty[a-2] = d;
            end
        end
    end

    function automatic logic [31:0] exp_rd(int a);
        if (a == 0) return {30'b0, m_pend, m_en};
        if (a == 1) return 32'(m_per);
        if (a < NUM_CH + 2) return 32'(m_duty[a-2]);
        return 32'd0;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("pwm_out", pwm_out, m_pwm);
        chk("period_tick", period_tick, m_tick);
        chk("readdata", readdata, exp_rd(int'(address)));
    end

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic wr(input int a, input int d);
        chipselect = 1; write_n = 0; address = ADDR_W'(a); writedata = 32'(d);
        cycle();
        chipselect = 0; write_n = 1;
    endtask

    task automatic rd_chk(input string nm, input int a, input int exp);
        address = ADDR_W'(a); #1;
        chk(nm, readdata, exp);
    endtask

    task automatic wait_tick();
        int k = 0;
        do begin cycle(); k++; end while (!period_tick && k < 300);
        if (!period_tick) chk("tick_timeout", 0, 1);
    endtask

    task automatic count(input int ch, input int n, output int hi, output int tk);
        hi = 0; tk = 0;
        repeat (n) begin
            @(negedge clk);
            hi += int'(pwm_out[ch]);
            tk += int'(period_tick);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int hi, tk, r, a;
        reset = 1; chipselect = 0; write_n = 1; address = '0; writedata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 0;
        cycle();

        // reset state
        for (int i = 0; i < NUM_CH + 2; i++) rd_chk("reset_reg", i, 0);
        count(0, 20, hi, tk);
        chk("reset_pwm", pwm_out, 0);
        chk("reset_ticks", tk, 0);

        // PERIOD=9 DUTY0=4 DUTY1=0
        wr(1, 9); wr(2, 4); wr(3, 0); wr(0, 1);
        wait_tick();
        count(0, 30, hi, tk);
        chk("duty4_highs", hi, 12);
        chk("duty4_ticks", tk, 3);
        count(1, 30, hi, tk);
        chk("duty0_highs", hi, 0);

        // mid-period DUTY0=7
        wait_tick();
        repeat (3) cycle();
        wr(2, 7);
        rd_chk("pending_set", 0, 3);
        wait_tick();
        rd_chk("pending_clr", 0, 1);
        count(0, 30, hi, tk);
        chk("duty7_highs", hi, 21);

        // duty above period, then PERIOD=0
        wr(4, 200);
        wait_tick(); wait_tick();
        count(2, 30, hi, tk);
        chk("duty_gt_per", hi, 30);
        wr(1, 0); wr(2, 1);
        wait_tick(); wait_tick();
        count(0, 20, hi, tk);
        chk("per0_highs", hi, 20);
        chk("per0_ticks", tk, 20);

        // write exactly on the wrap edge
        wr(1, 9); wr(2, 4);
        wait_tick(); wait_tick();
        repeat (9) cycle();
        wr(2, 2);
        rd_chk("wrap_wr_pending", 0, 3);
        count(0, 10, hi, tk);
        chk("wrap_old_duty", hi, 4);
        rd_chk("wrap_pending_clr", 0, 1);
        count(0, 10, hi, tk);
        chk("wrap_new_duty", hi, 2);

        // disable mid-pulse
        wait_tick();
        wr(0, 0);
        chk("dis_still_high", pwm_out[0], 1);
        cycle();
        chk("dis_low", pwm_out[0], 0);
        count(0, 20, hi, tk);
        chk("dis_ticks", tk, 0);

        // reset mid-period
        wr(0, 1);
        repeat (5) cycle();
        #3 reset = 1;
        #1 chk("rst_pwm", pwm_out, 0);
        for (int i = 0; i < NUM_CH + 2; i++) rd_chk("rst_reg", i, 0);
        @(negedge clk) reset = 0;
        cycle();
        count(0, 20, hi, tk);
        chk("post_rst_highs", hi, 0);
        chk("post_rst_ticks", tk, 0);
        wr(1, 9); wr(2, 4); wr(0, 1);
        wait_tick();
        count(0, 30, hi, tk);
        chk("resume_highs", hi, 12);

        // random traffic, model checks every cycle
        repeat (2500) begin
            r = $urandom_range(0, 99);
            chipselect = 0; write_n = 1;
            address = ADDR_W'($urandom_range(0, 31));
            writedata = $urandom;
            if (r < 12) begin
                chipselect = 1; write_n = 0;
                a = (r < 2) ? $urandom_range(0, 31) : $urandom_range(0, NUM_CH + 1);
                address = ADDR_W'(a);
                if (a == 0)
                    writedata = ($urandom & 32'hFFFF_FFFE) | 32'($urandom_range(0, 9) != 0);
                else if (a == 1)
                    writedata = ($urandom & 32'hFFFF_FF00) |
                                (($urandom_range(0, 9) == 0) ? 32'd255 : 32'($urandom_range(0, 20)));
                else if (a < NUM_CH + 2)
                    writedata = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 24));
            end else if (r < 20) begin
                chipselect = 0; write_n = 0;
            end else if (r < 30) begin
                chipselect = 1; write_n = 1;
            end
            cycle();
        end
        chipselect = 0; write_n = 1;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
